xcfi_check_sequencer: RTL and testbench
=======================================

# xcfi_check_sequencer

Sequences the single formal check window of the instruction checker. It watches the RVFI retirement stream on one channel and holds off until reset and a warm-up period have passed. It then skips a programmable number of eligible retirements and drives the one-cycle `check` strobe on the next eligible retirement. It sits between the core's RVFI trace outputs and the `check` input of every per-instruction checker instance, and reports progress, timeout and retirement-count status for cover properties.

## Interface

Parameters:
- NRET, 1, number of RVFI retirement channels
- CHANNEL_IDX, 0, channel this sequencer monitors (0..NRET-1)
- WARMUP_CYCLES, 4, cycles after reset deassertion before arming (0 allowed)
- SKIP_RETIRE, 0, eligible retirements skipped before the checked one
- TIMEOUT, 64, max cycles spent in ARMED before giving up (must be ≥1)
- IGNORE_INTR, 1, if 1, retirements with `rvfi_intr` set are not eligible

Ports:
- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; forces all state to reset values immediately
- enable  in  1  permits leaving IDLE; sampled each cycle
- rvfi_valid  in  NRET  retirement valid per channel
- rvfi_trap  in  NRET  retirement trapped
- rvfi_halt  in  NRET  retirement is last before halt
- rvfi_intr  in  NRET  retirement is first of trap handler
- check  out  1  check strobe to checkers (Mealy, same cycle as retirement)
- armed  out  1  state is ARMED
- done  out  1  check was issued (sticky until reset)
- timed_out  out  1  window expired or halted without check (sticky until reset)
- checked_trap  out  1  registered `rvfi_trap` of the checked retirement
- retire_count  out  16  saturating count of valid retirements on CHANNEL_IDX

## Operation

- Eligible retirement: `e = rvfi_valid[CH] && !(IGNORE_INTR && rvfi_intr[CH])`.
- States: IDLE, WARMUP, ARMED, DONE, EXPIRED. Reset value is IDLE.
- IDLE: when `enable` is high, go to WARMUP, load warm-up counter = WARMUP_CYCLES. If WARMUP_CYCLES == 0, go directly to ARMED.
- WARMUP: decrement each cycle. At 1→0, go to ARMED, load skip counter = SKIP_RETIRE and timeout counter = TIMEOUT.
- ARMED:
  - `check = e && skip == 0`. On check, go to DONE and latch `checked_trap <= rvfi_trap[CH]`.
  - `e && skip != 0`: decrement skip.
  - If that skipped retirement also has `rvfi_halt`, go to EXPIRED.
  - Otherwise decrement the timeout counter. When it reaches 0 without a check, go to EXPIRED.
  - A check on the same cycle as timeout expiry wins: go to DONE.
- DONE and EXPIRED are terminal; only `reset` leaves them. `check` is never asserted outside ARMED.
- `enable` falling after IDLE has no effect.
- `retire_count` increments on every `rvfi_valid[CH]` (intr included), in any state, saturating at 0xFFFF.
- Reset values: check 0, armed 0, done 0, timed_out 0, checked_trap 0, retire_count 0.

## Timing

- `check` is combinational from registered state/skip and current RVFI inputs. No added latency, so it coincides with the retirement the checker samples.
- `armed`, `done`, `timed_out` and `checked_trap` are registered. `done` rises the cycle after `check`.
- Minimum reset-to-check:
  - WARMUP_CYCLES = 0: 1 cycle for IDLE→ARMED with `enable` high at reset release, then check on the first eligible retirement.
  - Otherwise: 1 + WARMUP_CYCLES cycles.
- Retirements during IDLE/WARMUP are counted but never checked or skipped.
- Reset asserted mid-window: asynchronous return to IDLE, and `check` deasserts in the same cycle.
- At most one `check` per reset epoch.

## Structure

- Shared package `xcfi_pkg`: state enum `xcfi_seq_state_t`, `XCFI_RETIRE_CNT_W = 16`, and a counter-width function `clog2` used to size the warm-up, skip and timeout counters.
- One sub-module: `xcfi_sat_counter` (parameter width, inputs inc/clr, asynchronous active-high reset, saturating) for `retire_count`. The down-counters stay inline.

## Test plan

- Defaults, `enable` = 1 from reset, valid retirement at cycle 7 → `check` = 1 at cycle 7 only, `done` = 1 at cycle 8, `retire_count` = 1.
- SKIP_RETIRE = 2, eligible retirements at cycles 6, 8, 9 → `check` only at 9. With intr on the cycle-8 retirement (IGNORE_INTR = 1), `check` moves to the next eligible retirement.
- TIMEOUT = 3, no retirements after arming → EXPIRED, `timed_out` = 1 three cycles after `armed` rises, `check` never asserted.
- SKIP_RETIRE = 1, first retirement carries `rvfi_halt` → EXPIRED, no check. Separately, check with `rvfi_trap` = 1 → `checked_trap` = 1.
- Assert `reset` while ARMED with `rvfi_valid` high → `check` drops the same cycle, all outputs return to 0. The window replays after release.
- 70000 valid retirements → `retire_count` holds 0xFFFF.

Source files
------------

// File: rtl/xcfi_pkg.sv
// ----------------------------------------------------------------------------
// xcfi_pkg
// Definitions shared by the check sequencer and its helpers:
//   xcfi_seq_state_t  - states of the check-window sequencer
//   XCFI_RETIRE_CNT_W - width of the saturating retirement counter
//   clog2 / cnt_width - width helpers for the inline down-counters
// ----------------------------------------------------------------------------
package xcfi_pkg;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_WARMUP,
        SEQ_ARMED,
        SEQ_DONE,
        SEQ_EXPIRED
    } xcfi_seq_state_t;

    localparam int XCFI_RETIRE_CNT_W = 16;

    // Ceiling log2; clog2(1) is 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    // Bits needed to hold 0..max_value, never less than one bit so that a
    // zero-valued counter parameter still yields a legal vector.
    function automatic int cnt_width(input int max_value);
        int w;
        w = clog2(max_value + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/xcfi_sat_counter.sv
// ----------------------------------------------------------------------------
// xcfi_sat_counter
// Up-counter that sticks at its all-ones value instead of wrapping.
// Ports:
//   clock  - rising-edge clock
//   reset  - asynchronous active-high reset, clears the count
//   inc    - add one this cycle (ignored once saturated)
//   clr    - synchronous clear, takes priority over inc
//   count  - current count
// ----------------------------------------------------------------------------
module xcfi_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: clear wins, otherwise step up only while below all-ones so
    // the counter holds its maximum rather than rolling over to zero.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Count register with asynchronous clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/xcfi_check_sequencer.sv
// ----------------------------------------------------------------------------
// xcfi_check_sequencer
// Chooses the single retirement on one RVFI channel that the formal
// instruction checkers examine. After enable and a warm-up delay the window
// arms, skips SKIP_RETIRE eligible retirements and strobes check on the next
// one. The window gives up after TIMEOUT armed cycles or when a skipped
// retirement is the last one before halt.
// Ports:
//   clock, reset        - clock and asynchronous active-high reset
//   enable              - lets the sequencer leave IDLE
//   rvfi_valid/trap/
//   rvfi_halt/intr      - RVFI retirement flags, one bit per channel
//   check               - one-cycle strobe, same cycle as the chosen retirement
//   armed               - window is open
//   done                - check has been issued (sticky)
//   timed_out           - window closed without a check (sticky)
//   checked_trap        - trap flag of the checked retirement
//   retire_count        - saturating count of valid retirements on the channel
// ----------------------------------------------------------------------------
module xcfi_check_sequencer
    import xcfi_pkg::*;
#(
    parameter int NRET          = 1,
    parameter int CHANNEL_IDX   = 0,
    parameter int WARMUP_CYCLES = 4,
    parameter int SKIP_RETIRE   = 0,
    parameter int TIMEOUT       = 64,
    parameter int IGNORE_INTR   = 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [NRET-1:0]              rvfi_valid,
    input  logic [NRET-1:0]              rvfi_trap,
    input  logic [NRET-1:0]              rvfi_halt,
    input  logic [NRET-1:0]              rvfi_intr,
    output logic                         check,
    output logic                         armed,
    output logic                         done,
    output logic                         timed_out,
    output logic                         checked_trap,
    output logic [XCFI_RETIRE_CNT_W-1:0] retire_count
);

    localparam int WARM_W = cnt_width(WARMUP_CYCLES);
    localparam int SKIP_W = cnt_width(SKIP_RETIRE);
    localparam int TMO_W  = cnt_width(TIMEOUT);

    xcfi_seq_state_t state_q, state_d;
    logic [WARM_W-1:0] warm_q, warm_d;
    logic [SKIP_W-1:0] skip_q, skip_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              trap_q, trap_d;
    logic              eligible;

    // A retirement counts toward the window unless it is the first
    // instruction of an interrupt handler and those are being ignored.
    assign eligible = rvfi_valid[CHANNEL_IDX] &&
                      !((IGNORE_INTR != 0) && rvfi_intr[CHANNEL_IDX]);

    // The strobe is deliberately combinational so it lines up with the very
    // retirement the checkers sample; the async reset drops state_q out of
    // ARMED immediately, which also kills the strobe in the reset cycle.
    assign check = (state_q == SEQ_ARMED) && eligible && (skip_q == '0);

    // Next-state logic. The warm-up, skip and timeout down-counters live here
    // too. A check takes precedence over both halt and timeout expiry, and
    // DONE/EXPIRED hold until reset so only one check happens per epoch.
    always_comb begin
        state_d = state_q;
        warm_d  = warm_q;
        skip_d  = skip_q;
        tmo_d   = tmo_q;
        trap_d  = trap_q;

        case (state_q)
            SEQ_IDLE: begin
                if (enable) begin
                    if (WARMUP_CYCLES == 0) begin
                        state_d = SEQ_ARMED;
                        skip_d  = SKIP_W'(SKIP_RETIRE);
                        tmo_d   = TMO_W'(TIMEOUT);
                    end else begin
                        state_d = SEQ_WARMUP;
                        warm_d  = WARM_W'(WARMUP_CYCLES);
                    end
                end
            end

            SEQ_WARMUP: begin
                warm_d = warm_q - WARM_W'(1);
                if (warm_q == WARM_W'(1)) begin
                    state_d = SEQ_ARMED;
                    skip_d  = SKIP_W'(SKIP_RETIRE);
                    tmo_d   = TMO_W'(TIMEOUT);
                end
            end

            SEQ_ARMED: begin
                if (check) begin
                    state_d = SEQ_DONE;
                    trap_d  = rvfi_trap[CHANNEL_IDX];
                end else begin
                    // Without a check, an eligible retirement must be one
                    // still being skipped.
                    if (eligible) begin
                        skip_d = skip_q - SKIP_W'(1);
                    end
                    if (eligible && rvfi_halt[CHANNEL_IDX]) begin
                        state_d = SEQ_EXPIRED;
                    end else begin
                        tmo_d = tmo_q - TMO_W'(1);
                        if (tmo_q == TMO_W'(1)) begin
                            state_d = SEQ_EXPIRED;
                        end
                    end
                end
            end

            default: begin
                state_d = state_q;
            end
        endcase
    end

    // State and counter registers, all cleared asynchronously.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= SEQ_IDLE;
            warm_q  <= '0;
            skip_q  <= '0;
            tmo_q   <= '0;
            trap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            warm_q  <= warm_d;
            skip_q  <= skip_d;
            tmo_q   <= tmo_d;
            trap_q  <= trap_d;
        end
    end

    assign armed        = (state_q == SEQ_ARMED);
    assign done         = (state_q == SEQ_DONE);
    assign timed_out    = (state_q == SEQ_EXPIRED);
    assign checked_trap = trap_q;

    // Every valid retirement on the channel is counted, whatever the state
    // and whether or not it is an interrupt entry.
    xcfi_sat_counter #(
        .WIDTH (XCFI_RETIRE_CNT_W)
    ) u_retire_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (rvfi_valid[CHANNEL_IDX]),
        .clr   (1'b0),
        .count (retire_count)
    );

endmodule

// File: tb/tb_xcfi_check_sequencer.sv
// ----------------------------------------------------------------------------
// tb_xcfi_check_sequencer
// Drives two sequencers with different parameter sets from the same random
// RVFI stream and compares every output each cycle against a model that
// reasons in terms of arming time, eligible-retirement counts and window
// age. Each epoch ends with a mid-cycle asynchronous reset; a long final run
// exercises saturation of the retirement counter.
// ----------------------------------------------------------------------------
module tb_xcfi_check_sequencer;

    localparam int NUM_DUT = 2;
    localparam int RES_NONE = 0;
    localparam int RES_DONE = 1;
    localparam int RES_EXP  = 2;

    // Instance A: warm-up, skipping and interrupt filtering.
    localparam int W_A = 3;
    localparam int S_A = 2;
    localparam int T_A = 12;
    localparam int I_A = 1;
    // Instance B: no warm-up, first eligible retirement, short window.
    localparam int W_B = 0;
    localparam int S_B = 0;
    localparam int T_B = 5;
    localparam int I_B = 0;

    int p_warm [NUM_DUT] = '{W_A, W_B};
    int p_skip [NUM_DUT] = '{S_A, S_B};
    int p_tmo  [NUM_DUT] = '{T_A, T_B};
    int p_intr [NUM_DUT] = '{I_A, I_B};

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [0:0] rvfi_valid = '0;
    logic [0:0] rvfi_trap  = '0;
    logic [0:0] rvfi_halt  = '0;
    logic [0:0] rvfi_intr  = '0;

    logic [NUM_DUT-1:0] check_o;
    logic [NUM_DUT-1:0] armed_o;
    logic [NUM_DUT-1:0] done_o;
    logic [NUM_DUT-1:0] tout_o;
    logic [NUM_DUT-1:0] trap_o;
    logic [15:0]        cnt_o [NUM_DUT];

    // Reference model state per instance.
    bit m_started [NUM_DUT];
    int m_arm     [NUM_DUT];
    int m_elig    [NUM_DUT];
    int m_result  [NUM_DUT];
    bit m_trap    [NUM_DUT];
    int m_cnt     [NUM_DUT];

    int n_compared   = 0;
    int n_mismatched = 0;

    // Free-running clock, 10 time units per cycle.
    always #5 clock = ~clock;

    xcfi_check_sequencer #(
        .NRET          (1),
        .CHANNEL_IDX   (0),
        .WARMUP_CYCLES (W_A),
        .SKIP_RETIRE   (S_A),
        .TIMEOUT       (T_A),
        .IGNORE_INTR   (I_A)
    ) dut_a (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .rvfi_valid   (rvfi_valid),
        .rvfi_trap    (rvfi_trap),
        .rvfi_halt    (rvfi_halt),
        .rvfi_intr    (rvfi_intr),
        .check        (check_o[0]),
        .armed        (armed_o[0]),
        .done         (done_o[0]),
        .timed_out    (tout_o[0]),
        .checked_trap (trap_o[0]),
        .retire_count (cnt_o[0])
    );

    xcfi_check_sequencer #(
        .NRET          (1),
        .CHANNEL_IDX   (0),
        .WARMUP_CYCLES (W_B),
        .SKIP_RETIRE   (S_B),
        .TIMEOUT       (T_B),
        .IGNORE_INTR   (I_B)
    ) dut_b (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .rvfi_valid   (rvfi_valid),
        .rvfi_trap    (rvfi_trap),
        .rvfi_halt    (rvfi_halt),
        .rvfi_intr    (rvfi_intr),
        .check        (check_o[1]),
        .armed        (armed_o[1]),
        .done         (done_o[1]),
        .timed_out    (tout_o[1]),
        .checked_trap (trap_o[1]),
        .retire_count (cnt_o[1])
    );

    // The one comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (time %0t)",
                     tag, actual, expected, $time);
        end
    endtask

    // Clears the model to its post-reset picture.
    task automatic modelReset();
        for (int i = 0; i < NUM_DUT; i++) begin
            m_started[i] = 1'b0;
            m_arm[i]     = 0;
            m_elig[i]    = 0;
            m_result[i]  = RES_NONE;
            m_trap[i]    = 1'b0;
            m_cnt[i]     = 0;
        end
    endtask

    // Random RVFI traffic and enable for cycle t of an epoch.
    task automatic applyStimulus(input int t);
        if (t == 0) begin
            enable = ($urandom_range(0, 1) == 0);
        end else begin
            enable = ($urandom_range(0, 3) == 0);
        end
        rvfi_valid[0] = ($urandom_range(0, 9) < 4);
        rvfi_intr[0]  = ($urandom_range(0, 3) == 0);
        rvfi_halt[0]  = ($urandom_range(0, 9) == 0);
        rvfi_trap[0]  = ($urandom_range(0, 1) == 1);
    endtask

    // Compare outputs for cycle t, then advance the model past the edge.
    // The window is open from m_arm (enable cycle + 1 + warm-up) until a
    // result is recorded; the check goes to eligible retirement number
    // SKIP+1 inside it, and the window closes after TIMEOUT cycles or on a
    // halting skipped retirement.
    task automatic compareAndStep(input int t);
        for (int i = 0; i < NUM_DUT; i++) begin
            bit in_win;
            bit elig;
            bit exp_check;
            in_win    = m_started[i] && (t >= m_arm[i]) && (m_result[i] == RES_NONE);
            elig      = rvfi_valid[0] && !((p_intr[i] != 0) && rvfi_intr[0]);
            exp_check = in_win && elig && (m_elig[i] == p_skip[i]);

            checkOutput($sformatf("check%0d", i), 32'(check_o[i]), 32'(exp_check));
            checkOutput($sformatf("armed%0d", i), 32'(armed_o[i]), 32'(in_win));
            checkOutput($sformatf("done%0d", i), 32'(done_o[i]),
                        32'(m_result[i] == RES_DONE));
            checkOutput($sformatf("timed_out%0d", i), 32'(tout_o[i]),
                        32'(m_result[i] == RES_EXP));
            checkOutput($sformatf("checked_trap%0d", i), 32'(trap_o[i]), 32'(m_trap[i]));
            checkOutput($sformatf("retire_count%0d", i), 32'(cnt_o[i]), m_cnt[i]);

            if (in_win) begin
                if (exp_check) begin
                    m_result[i] = RES_DONE;
                    m_trap[i]   = rvfi_trap[0];
                end else begin
                    if (elig) begin
                        m_elig[i]++;
                        if (rvfi_halt[0]) m_result[i] = RES_EXP;
                    end
                    if ((m_result[i] == RES_NONE) && ((t - m_arm[i] + 1) >= p_tmo[i]))
                        m_result[i] = RES_EXP;
                end
            end
            if (!m_started[i] && enable) begin
                m_started[i] = 1'b1;
                m_arm[i]     = t + 1 + p_warm[i];
            end
            if (rvfi_valid[0] && (m_cnt[i] < 65535)) m_cnt[i]++;
        end
    endtask

    // Main sequence: random epochs ended by asynchronous reset, then the
    // long saturation run.
    initial begin
        int len;
        modelReset();
        repeat (2) @(posedge clock);
        #1;
        for (int ep = 0; ep < 60; ep++) begin
            len = $urandom_range(8, 40);
            reset = 1'b0;
            modelReset();
            for (int t = 0; t < len; t++) begin
                if (t > 0) begin
                    @(posedge clock);
                    #1;
                end
                applyStimulus(t);
                @(negedge clock);
                compareAndStep(t);
            end
            // Mid-cycle reset with a valid, non-interrupt retirement present:
            // everything, including the combinational strobe, must clear now.
            rvfi_valid[0] = 1'b1;
            rvfi_intr[0]  = 1'b0;
            reset = 1'b1;
            #1;
            for (int i = 0; i < NUM_DUT; i++) begin
                checkOutput($sformatf("rst_check%0d", i), 32'(check_o[i]), 0);
                checkOutput($sformatf("rst_armed%0d", i), 32'(armed_o[i]), 0);
                checkOutput($sformatf("rst_done%0d", i), 32'(done_o[i]), 0);
                checkOutput($sformatf("rst_timed_out%0d", i), 32'(tout_o[i]), 0);
                checkOutput($sformatf("rst_trap%0d", i), 32'(trap_o[i]), 0);
                checkOutput($sformatf("rst_count%0d", i), 32'(cnt_o[i]), 0);
            end
            @(posedge clock);
            #1;
        end

        // Saturation: stay in IDLE with a retirement every cycle.
        enable        = 1'b0;
        rvfi_valid[0] = 1'b1;
        rvfi_intr[0]  = 1'b0;
        rvfi_halt[0]  = 1'b0;
        rvfi_trap[0]  = 1'b0;
        reset         = 1'b0;
        repeat (65534) @(posedge clock);
        #1;
        for (int i = 0; i < NUM_DUT; i++) begin
            checkOutput($sformatf("count_near_max%0d", i), 32'(cnt_o[i]), 65534);
            checkOutput($sformatf("idle_armed%0d", i), 32'(armed_o[i]), 0);
        end
        repeat (70000 - 65534) @(posedge clock);
        #1;
        for (int i = 0; i < NUM_DUT; i++) begin
            checkOutput($sformatf("count_sat%0d", i), 32'(cnt_o[i]), 32'hFFFF);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
